// File: rtl/dm_pkg.sv
// Shared debug-transport definitions: JTAG instruction codes, TAP controller
// states and the DTMCS register layout. Imported by the TAP datapath and FSM.
package dm;

  // JTAG instruction register codes; unlisted codes select BYPASS.
  typedef enum logic [4:0] {
    IrBypass0   = 5'h00,
    IrIdcode    = 5'h01,
    IrDtmcs     = 5'h10,
    IrDmiAccess = 5'h11,
    IrBypass1   = 5'h1f
  } ir_e;

  // IEEE 1149.1 TAP controller states.
  typedef enum logic [3:0] {
    TestLogicReset,
    RunTestIdle,
    SelectDrScan,
    CaptureDr,
    ShiftDr,
    Exit1Dr,
    PauseDr,
    Exit2Dr,
    UpdateDr,
    SelectIrScan,
    CaptureIr,
    ShiftIr,
    Exit1Ir,
    PauseIr,
    Exit2Ir,
    UpdateIr
  } tap_state_e;

  typedef struct packed {
    logic [13:0] zero;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero1;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  localparam logic [3:0] DtmVersion = 4'd1;
  // Suggested Run-Test/Idle cycles between DMI accesses.
  localparam logic [2:0] DtmIdle    = 3'd1;

endpackage

// File: rtl/dtm_jtag_tap_if.sv
// Link between the DTM TAP front end and the downstream DMI request/response FSM.
//   master (TAP side): drives TAP state strobes, IR selects, dmi_reset pulse and
//                      forwarded TDI; receives sticky DMI error and DMI shift LSB.
//   slave  (DMI FSM) : the mirror image.
interface dtm_jtag_tap_if;

  logic       test_logic_reset;
  logic       shift_dr;
  logic       update_dr;
  logic       capture_dr;
  logic       dmi_access;
  logic       dtmcs_select;
  logic       dmi_reset;
  logic [1:0] dmi_error;
  logic       dmi_tdi;
  logic       dmi_tdo;

  modport master (
    output test_logic_reset, shift_dr, update_dr, capture_dr,
    output dmi_access, dtmcs_select, dmi_reset, dmi_tdi,
    input  dmi_error, dmi_tdo
  );

  modport slave (
    input  test_logic_reset, shift_dr, update_dr, capture_dr,
    input  dmi_access, dtmcs_select, dmi_reset, dmi_tdi,
    output dmi_error, dmi_tdo
  );

endinterface

// File: rtl/dtm_jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller, advanced by tms_i on posedge tck_i.
// Ports:
//   tck_i, trst_ni        : test clock, asynchronous active-low reset
//   tms_i                 : test mode select
//   *_o                   : one flag per TAP state the datapath cares about
// The flags are registered from the next state, so each one is exactly the
// decode of the current state with no combinational path behind it.
module dtm_jtag_tap_fsm
  import dm::*;
(
  input  logic tck_i,
  input  logic trst_ni,
  input  logic tms_i,
  output logic test_logic_reset_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic update_dr_o,
  output logic capture_ir_o,
  output logic shift_ir_o,
  output logic update_ir_o
);

  tap_state_e state_q, state_d;

  always_comb begin
    state_d = TestLogicReset;
    unique case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q            <= TestLogicReset;
      test_logic_reset_o <= 1'b1;
      capture_dr_o       <= 1'b0;
      shift_dr_o         <= 1'b0;
      update_dr_o        <= 1'b0;
      capture_ir_o       <= 1'b0;
      shift_ir_o         <= 1'b0;
      update_ir_o        <= 1'b0;
    end else begin
      state_q            <= state_d;
      test_logic_reset_o <= (state_d == TestLogicReset);
      capture_dr_o       <= (state_d == CaptureDr);
      shift_dr_o         <= (state_d == ShiftDr);
      update_dr_o        <= (state_d == UpdateDr);
      capture_ir_o       <= (state_d == CaptureIr);
      shift_ir_o         <= (state_d == ShiftIr);
      update_ir_o        <= (state_d == UpdateIr);
    end
  end

endmodule

// File: rtl/dtm_jtag_tap.sv
// JTAG TAP and RISC-V Debug Transport Module front end (tck domain only).
// Hosts the IR, IDCODE, BYPASS and DTMCS registers; DMIACCESS lives downstream.
// Ports:
//   tck_i, trst_ni  : test clock, asynchronous active-low reset
//   tms_i, td_i     : test mode select, test data in (sampled on posedge)
//   td_o, tdo_oe_o  : test data out and its drive enable (updated on negedge)
//   testmode_i      : scan mode, moves the negedge flops onto posedge
//   dmi             : strobes, selects and serial path to the DMI FSM
module dtm_jtag_tap
  import dm::*;
#(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h0000_0001,
  parameter int unsigned AbitsValue  = 7
) (
  input  logic          tck_i,
  input  logic          trst_ni,
  input  logic          tms_i,
  input  logic          td_i,
  output logic          td_o,
  output logic          tdo_oe_o,
  input  logic          testmode_i,
  dtm_jtag_tap_if.master dmi
);

  localparam logic [IrLength-1:0] IrIdcodeVal    = IrLength'(IrIdcode);
  localparam logic [IrLength-1:0] IrDtmcsVal     = IrLength'(IrDtmcs);
  localparam logic [IrLength-1:0] IrDmiAccessVal = IrLength'(IrDmiAccess);

  logic test_logic_reset, capture_dr, shift_dr, update_dr;
  logic capture_ir, shift_ir, update_ir;

  dtm_jtag_tap_fsm u_tap_fsm (
    .tck_i              (tck_i),
    .trst_ni            (trst_ni),
    .tms_i              (tms_i),
    .test_logic_reset_o (test_logic_reset),
    .capture_dr_o       (capture_dr),
    .shift_dr_o         (shift_dr),
    .update_dr_o        (update_dr),
    .capture_ir_o       (capture_ir),
    .shift_ir_o         (shift_ir),
    .update_ir_o        (update_ir)
  );

  // Instruction register. The shift stage only reaches ir_q in UpdateIr, so an
  // IR scan cut short by trst_ni never changes the active instruction.
  logic [IrLength-1:0] ir_q, ir_shift_q;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_shift_q <= '0;
      ir_q       <= IrIdcodeVal;
    end else begin
      if (capture_ir) begin
        ir_shift_q <= IrLength'(1);
      end else if (shift_ir) begin
        ir_shift_q <= {td_i, ir_shift_q[IrLength-1:1]};
      end
      if (test_logic_reset) begin
        ir_q <= IrIdcodeVal;
      end else if (update_ir) begin
        ir_q <= ir_shift_q;
      end
    end
  end

  logic sel_idcode, sel_dtmcs, sel_dmi, sel_bypass;

  assign sel_idcode = (ir_q == IrIdcodeVal);
  assign sel_dtmcs  = (ir_q == IrDtmcsVal);
  assign sel_dmi    = (ir_q == IrDmiAccessVal);
  assign sel_bypass = ~(sel_idcode | sel_dtmcs | sel_dmi);

  dtmcs_t dtmcs_capture;

  always_comb begin
    dtmcs_capture         = '0;
    dtmcs_capture.idle    = DtmIdle;
    dtmcs_capture.dmistat = dmi.dmi_error;
    dtmcs_capture.abits   = 6'(AbitsValue);
    dtmcs_capture.version = DtmVersion;
  end

  // Data registers: capture on CaptureDr, shift right with td_i entering the MSB.
  logic [31:0] idcode_q, dtmcs_q;
  logic        bypass_q;

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      idcode_q <= IdcodeValue;
      dtmcs_q  <= '0;
      bypass_q <= 1'b0;
    end else if (capture_dr) begin
      if (sel_idcode) idcode_q <= IdcodeValue;
      if (sel_dtmcs)  dtmcs_q  <= dtmcs_capture;
      if (sel_bypass) bypass_q <= 1'b0;
    end else if (shift_dr) begin
      if (sel_idcode) idcode_q <= {td_i, idcode_q[31:1]};
      if (sel_dtmcs)  dtmcs_q  <= {td_i, dtmcs_q[31:1]};
      if (sel_bypass) bypass_q <= td_i;
    end
  end

  logic tdo_d, dr_tdo;

  always_comb begin
    dr_tdo = bypass_q;
    if (sel_idcode)     dr_tdo = idcode_q[0];
    else if (sel_dtmcs) dr_tdo = dtmcs_q[0];
    else if (sel_dmi)   dr_tdo = dmi.dmi_tdo;
  end

  always_comb begin
    tdo_d = 1'b0;
    if (shift_ir)      tdo_d = ir_shift_q[0];
    else if (shift_dr) tdo_d = dr_tdo;
  end

  // TDO launches on the falling edge; in scan mode the same flops move to the
  // rising edge so the whole block sits on one clock phase.
  logic tck_n;
  logic td_q, tdo_oe_q;

  assign tck_n = testmode_i ? tck_i : ~tck_i;

  always_ff @(posedge tck_n or negedge trst_ni) begin
    if (!trst_ni) begin
      td_q     <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      td_q     <= tdo_d;
      tdo_oe_q <= shift_ir | shift_dr;
    end
  end

  assign td_o     = td_q;
  assign tdo_oe_o = tdo_oe_q;

  assign dmi.test_logic_reset = test_logic_reset;
  assign dmi.shift_dr         = shift_dr;
  assign dmi.update_dr        = update_dr;
  assign dmi.capture_dr       = capture_dr;
  assign dmi.dmi_access       = sel_dmi;
  assign dmi.dtmcs_select     = sel_dtmcs;
  // UpdateDr lasts a single tck, so this is a one-cycle pulse; dmihardreset
  // (bit 17) is deliberately not acted on.
  assign dmi.dmi_reset        = sel_dtmcs & update_dr & dtmcs_q[16];
  assign dmi.dmi_tdi          = td_i;

endmodule

// File: tb/tb_dtm_jtag_tap.sv
// Bench for dtm_jtag_tap: a transaction-level TAP model (state graph table plus
// a generic length-N shift register) is checked against the DUT every cycle,
// with hand-computed literal expectations on the shifted-out data.
module tb_dtm_jtag_tap;

  localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7;
  localparam int UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14;
  localparam int UIR = 15;

  // 1149.1 state graph: next state for tms=0 and tms=1.
  int nxt0[16] = '{RTI, RTI, CDR, SHDR, SHDR, PDR, PDR, SHDR, RTI, CIR, SHIR, SHIR, PIR, PIR,
                   SHIR, RTI};
  int nxt1[16] = '{TLR, SDR, SIR, E1DR, E1DR, UDR, E2DR, UDR, SDR, TLR, E1IR, E1IR, UIR, E2IR,
                   UIR, SDR};

  logic tck = 1'b0, trst_n = 1'b0, tms = 1'b1, tdi = 1'b0, testmode = 1'b0;
  logic tdo, oe;

  dtm_jtag_tap_if dmi_if ();

  dtm_jtag_tap #(
    .IrLength    (5),
    .IdcodeValue (32'h0000_0001),
    .AbitsValue  (7)
  ) dut (
    .tck_i      (tck),
    .trst_ni    (trst_n),
    .tms_i      (tms),
    .td_i       (tdi),
    .td_o       (tdo),
    .tdo_oe_o   (oe),
    .testmode_i (testmode),
    .dmi        (dmi_if)
  );

  always #5 tck = ~tck;

  int n_cmp = 0, n_err = 0;
  int upd_seen = 0, rst_seen = 0;
  bit cmp_en = 0;

  // Model state.
  int          m_state;
  logic [4:0]  m_ir, m_irsr;
  logic [31:0] m_dr;
  int          m_len;  // 0 = register lives downstream (DMIACCESS)

  function automatic void model_reset();
    m_state = TLR;
    m_ir    = 5'h01;
    m_irsr  = 5'h00;
    m_dr    = 32'h0;
    m_len   = 32;
  endfunction

  function automatic void model_advance(input logic t, input logic d);
    case (m_state)
      TLR:  m_ir = 5'h01;
      CIR:  m_irsr = 5'd1;
      SHIR: m_irsr = (m_irsr >> 1) | (5'(d) << 4);
      UIR:  m_ir = m_irsr;
      CDR: begin
        case (m_ir)
          5'h01: begin m_dr = 32'h0000_0001; m_len = 32; end
          5'h10: begin
            m_dr  = 32'd1 + 32'd7 * 16 + 32'(dmi_if.dmi_error) * 1024 + 32'd1 * 4096;
            m_len = 32;
          end
          5'h11:   m_len = 0;
          default: begin m_dr = 32'h0; m_len = 1; end
        endcase
      end
      SHDR: begin
        if (m_len == 32) m_dr = (m_dr >> 1) | (32'(d) << 31);
        else if (m_len == 1) m_dr = 32'(d);
      end
      default: ;
    endcase
    m_state = t ? nxt1[m_state] : nxt0[m_state];
  endfunction

  // {tlr, shift_dr, update_dr, capture_dr, dmi_access, dtmcs_sel, dmi_reset, td_o, oe, dmi_tdi}
  function automatic logic [9:0] model_outputs();
    logic acc, dsel, drst, etdo, eoe;
    acc  = (m_ir == 5'h11);
    dsel = (m_ir == 5'h10);
    drst = (m_state == UDR) && dsel && m_dr[16];
    etdo = 1'b0;
    if (m_state == SHIR) etdo = m_irsr[0];
    else if (m_state == SHDR) etdo = (m_len == 0) ? dmi_if.dmi_tdo : m_dr[0];
    eoe  = (m_state == SHIR) || (m_state == SHDR);
    return {m_state == TLR, m_state == SHDR, m_state == UDR, m_state == CDR, acc, dsel, drst,
            etdo, eoe, tdi};
  endfunction

  // Per-cycle comparison, one time unit after the falling edge.
  initial begin
    logic [9:0] act, exp;
    forever begin
      @(negedge tck);
      #1;
      if (cmp_en) begin
        act = {dmi_if.test_logic_reset, dmi_if.shift_dr, dmi_if.update_dr, dmi_if.capture_dr,
               dmi_if.dmi_access, dmi_if.dtmcs_select, dmi_if.dmi_reset, tdo, oe, dmi_if.dmi_tdi};
        exp = model_outputs();
        n_cmp++;
        if (act !== exp) begin
          n_err++;
          $display("FAIL cycle_outputs t=%0t model_state=%0d got %b expected %b",
                   $time, m_state, act, exp);
        end
        if (dmi_if.update_dr === 1'b1) upd_seen++;
        if (dmi_if.dmi_reset === 1'b1) rst_seen++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    model_advance(t, d);
    @(negedge tck);
    #2;
  endtask

  // Shift n bits LSB first; dout collects td_o as each bit leaves.
  task automatic shift_bits(input logic [31:0] din, input int n, input bit do_exit,
                            output logic [31:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      step(do_exit && (i == n - 1), din[i]);
    end
  endtask

  task automatic goto_shift_dr();  // from RunTestIdle
    step(1, 0); step(0, 0); step(0, 0);
  endtask

  task automatic goto_shift_ir();  // from RunTestIdle
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
  endtask

  task automatic update_to_idle();  // from Exit1
    step(1, 0); step(0, 0);
  endtask

  task automatic write_ir(input logic [4:0] code, output logic [31:0] captured);
    goto_shift_ir();
    shift_bits(32'(code), 5, 1, captured);
    update_to_idle();
  endtask

  initial begin
    logic [31:0] out;
    int r0, u0;
    dmi_if.dmi_error = 2'b00;
    dmi_if.dmi_tdo   = 1'b0;
    model_reset();
    @(negedge tck);
    #2;
    check("reset_outputs", {26'b0, dmi_if.test_logic_reset, dmi_if.shift_dr, dmi_if.dmi_access,
          dmi_if.dtmcs_select, tdo, oe}, 32'b10_0000);
    cmp_en = 1;
    trst_n = 1'b1;
    step(0, 0);

    // IDCODE readout, then five tms=1 from ShiftDr.
    goto_shift_dr();
    shift_bits(32'h0, 32, 0, out);
    check("idcode_shift", out, 32'h0000_0001);
    check("oe_in_shift_dr", 32'(oe), 32'd1);
    for (int i = 0; i < 4; i++) step(1, 0);
    check("tlr_after_4", 32'(dmi_if.test_logic_reset), 32'd0);
    step(1, 0);
    check("tlr_after_5", 32'(dmi_if.test_logic_reset), 32'd1);
    step(1, 0);
    step(0, 0);

    // BYPASS1: capture pattern out of IR, then one-bit delay.
    write_ir(5'h1f, out);
    check("ir_capture", out & 32'h1f, 32'h01);
    goto_shift_dr();
    shift_bits(32'b1101, 4, 1, out);
    check("bypass1_delay", out & 32'hf, 32'b1010);
    update_to_idle();

    // Unassigned code behaves as BYPASS.
    write_ir(5'h05, out);
    goto_shift_dr();
    shift_bits(32'b011, 3, 1, out);
    check("bypass_other", out & 32'h7, 32'b110);
    update_to_idle();

    // DTMCS capture with both error bits set.
    dmi_if.dmi_error = 2'b11;
    write_ir(5'h10, out);
    check("dtmcs_select", 32'(dmi_if.dtmcs_select), 32'd1);
    goto_shift_dr();
    shift_bits(32'h0, 32, 1, out);
    check("dtmcs_capture", out, 32'h0000_1c71);
    update_to_idle();
    dmi_if.dmi_error = 2'b00;

    // dmireset write pulses once; zero and dmihardreset do not.
    r0 = rst_seen;
    goto_shift_dr();
    shift_bits(32'h0001_0000, 32, 1, out);
    update_to_idle();
    check("dmireset_pulse", 32'(rst_seen - r0), 32'd1);
    r0 = rst_seen;
    goto_shift_dr();
    shift_bits(32'h0, 32, 1, out);
    update_to_idle();
    check("dmireset_zero", 32'(rst_seen - r0), 32'd0);
    r0 = rst_seen;
    goto_shift_dr();
    shift_bits(32'h0002_0000, 32, 1, out);
    update_to_idle();
    check("dmihardreset_ignored", 32'(rst_seen - r0), 32'd0);

    // DMIACCESS: td_o follows the downstream shift register LSB.
    write_ir(5'h11, out);
    check("dmi_access", 32'(dmi_if.dmi_access), 32'd1);
    dmi_if.dmi_tdo = 1'b1;
    goto_shift_dr();
    check("dmi_tdo_high", 32'(tdo), 32'd1);
    dmi_if.dmi_tdo = 1'b0;
    step(0, 1);
    check("dmi_tdo_low", 32'(tdo), 32'd0);
    check("dmi_tdi_follow", 32'(dmi_if.dmi_tdi), 32'd1);
    step(1, 0);
    update_to_idle();

    // trst_ni mid-ShiftIr: IR back to IDCODE, no update strobe.
    goto_shift_ir();
    step(0, 0);
    step(0, 0);
    u0 = upd_seen;
    trst_n = 1'b0;
    model_reset();
    @(negedge tck);
    #2;
    trst_n = 1'b1;
    check("reset_no_update", 32'(upd_seen - u0), 32'd0);
    check("reset_ir_idcode", 32'({dmi_if.dmi_access, dmi_if.dtmcs_select}), 32'd0);
    step(0, 0);
    goto_shift_dr();
    shift_bits(32'h0, 32, 1, out);
    check("idcode_after_reset", out, 32'h0000_0001);
    update_to_idle();

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
